// File: rtl/gpio_bus_slave.sv
// Memory-mapped GPIO port: output/direction registers, synchronised inputs,
// edge detection into a sticky W1C status register and a level interrupt.
module gpio_bus_slave #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gpio_ce,
  input  logic             bus_re,
  input  logic [3:0]       bus_we,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_OUT    = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_IN     = 3'd2;
  localparam logic [2:0] ADDR_EN     = 3'd3;
  localparam logic [2:0] ADDR_EDGE   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_SET    = 3'd6;
  localparam logic [2:0] ADDR_CLR    = 3'd7;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] out_q, dir_q, en_q, edge_q, status_q, prev_q;
  logic [WIDTH-1:0] in_w, rise, fall, evt;
  logic [WIDTH-1:0] lane_mask, wdata, ones_mask, clear_mask, rdata_w;
  logic [31:0]      lane_mask32;
  logic [2:0]       sel;
  logic             wr;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus_addr[31:5], bus_addr[1:0]};

  assign sel         = bus_addr[4:2];
  assign wr          = gpio_ce && (bus_we != 4'b0000);
  assign lane_mask32 = {{8{bus_we[3]}}, {8{bus_we[2]}}, {8{bus_we[1]}}, {8{bus_we[0]}}};
  assign lane_mask   = lane_mask32[WIDTH-1:0];
  assign wdata       = bus_wdata[WIDTH-1:0];
  // Disabled lanes behave as writing zeros for the W1C/SET/CLR registers.
  assign ones_mask   = wdata & lane_mask;
  assign clear_mask  = (wr && sel == ADDR_STATUS) ? ones_mask : '0;

  assign in_w = sync_q[SYNC_STAGES-1];
  assign rise = in_w & ~prev_q;
  assign fall = ~in_w & prev_q;
  assign evt  = en_q & ((edge_q & rise) | (~edge_q & fall));

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(status_q & en_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      dir_q    <= '0;
      en_q     <= '0;
      edge_q   <= '0;
      status_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      prev_q   <= in_w;
      // New events are ORed in after the clear so a simultaneous event wins.
      status_q <= (status_q & ~clear_mask) | evt;
      if (wr) begin
        case (sel)
          ADDR_OUT:  out_q  <= (out_q & ~lane_mask) | (wdata & lane_mask);
          ADDR_DIR:  dir_q  <= (dir_q & ~lane_mask) | (wdata & lane_mask);
          ADDR_EN:   en_q   <= (en_q & ~lane_mask) | (wdata & lane_mask);
          ADDR_EDGE: edge_q <= (edge_q & ~lane_mask) | (wdata & lane_mask);
          ADDR_SET:  out_q  <= out_q | ones_mask;
          ADDR_CLR:  out_q  <= out_q & ~ones_mask;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_w = '0;
    case (sel)
      ADDR_OUT:    rdata_w = out_q;
      ADDR_DIR:    rdata_w = dir_q;
      ADDR_IN:     rdata_w = in_w;
      ADDR_EN:     rdata_w = en_q;
      ADDR_EDGE:   rdata_w = edge_q;
      ADDR_STATUS: rdata_w = status_q;
      default:     rdata_w = '0;
    endcase
    bus_rdata = 32'h0;
    if (gpio_ce && bus_re) bus_rdata[WIDTH-1:0] = rdata_w;
  end

endmodule

// File: tb/tb_gpio_bus_slave.sv
// Bench for gpio_bus_slave: register-access vector table plus hand-written
// sequences for synchroniser latency, interrupts, the W1C race and reset.
module tb_gpio_bus_slave;

  logic        clk;
  logic        rst_n;
  logic        gpio_ce;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN = 3'd2, A_EN = 3'd3,
                         A_EDGE = 3'd4, A_STATUS = 3'd5, A_SET = 3'd6, A_CLR = 3'd7;

  typedef struct {
    bit          is_write;
    bit          ce;
    logic [2:0]  addr;
    logic [3:0]  we;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;

  gpio_bus_slave #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_ce(gpio_ce), .bus_re(bus_re), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual);
    logic [31:0] expected;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, scoreboard empty", name, actual);
    end else begin
      expected = exp_q.pop_front();
      if (actual !== expected) begin
        n_miss++;
        $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
    end
  endtask

  task automatic expectNow(input string name, input logic [31:0] actual, input logic [31:0] expected);
    exp_q.push_back(expected);
    checkOutput(name, actual);
  endtask

  task automatic busIdle();
    gpio_ce   = 1'b0;
    bus_re    = 1'b0;
    bus_we    = 4'b0000;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [3:0] we, input logic [31:0] data);
    @(negedge clk);
    gpio_ce   = 1'b1;
    bus_re    = 1'b0;
    bus_we    = we;
    bus_addr  = {27'h0, addr, 2'b00};
    bus_wdata = data;
    @(negedge clk);
    busIdle();
  endtask

  task automatic busRead(input logic [2:0] addr, input bit ce, input logic [31:0] expected,
                         input string name);
    @(negedge clk);
    gpio_ce  = ce;
    bus_re   = 1'b1;
    bus_we   = 4'b0000;
    bus_addr = {27'h0, addr, 2'b00};
    exp_q.push_back(expected);
    #2;
    checkOutput(name, bus_rdata);
    busIdle();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_write) busWrite(v.addr, v.we, v.data);
    else            busRead(v.addr, v.ce, v.data, v.name);
  endtask

  initial begin
    busIdle();
    gpio_in = 32'h0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Register access table; for reads, data is the expected value.
    vecs.push_back('{0, 1, A_OUT,    4'h0, 32'h0,        "reset_out"});
    vecs.push_back('{0, 1, A_DIR,    4'h0, 32'h0,        "reset_dir"});
    vecs.push_back('{0, 1, A_IN,     4'h0, 32'h0,        "reset_in"});
    vecs.push_back('{0, 1, A_STATUS, 4'h0, 32'h0,        "reset_status"});
    vecs.push_back('{1, 1, A_OUT,    4'h5, 32'hAABBCCDD, ""});
    vecs.push_back('{0, 1, A_OUT,    4'h0, 32'h00BB00DD, "byte_lanes"});
    vecs.push_back('{1, 1, A_OUT,    4'h0, 32'hFFFFFFFF, ""});
    vecs.push_back('{0, 1, A_OUT,    4'h0, 32'h00BB00DD, "no_lane_write"});
    vecs.push_back('{1, 1, A_OUT,    4'hF, 32'h000000F0, ""});
    vecs.push_back('{1, 1, A_SET,    4'hF, 32'h0000000F, ""});
    vecs.push_back('{1, 1, A_CLR,    4'hF, 32'h00000030, ""});
    vecs.push_back('{0, 1, A_OUT,    4'h0, 32'h000000CF, "set_clr"});
    vecs.push_back('{0, 1, A_SET,    4'h0, 32'h0,        "set_reads_0"});
    vecs.push_back('{0, 1, A_CLR,    4'h0, 32'h0,        "clr_reads_0"});
    vecs.push_back('{1, 1, A_SET,    4'h4, 32'hFFFFFFFF, ""});
    vecs.push_back('{0, 1, A_OUT,    4'h0, 32'h00FF00CF, "set_lane2"});
    vecs.push_back('{1, 1, A_DIR,    4'hF, 32'h12345678, ""});
    vecs.push_back('{0, 1, A_DIR,    4'h0, 32'h12345678, "dir_rw"});
    vecs.push_back('{0, 1, A_OUT,    4'h0, 32'h00FF00CF, "out_kept_by_dir"});
    vecs.push_back('{0, 0, A_OUT,    4'h0, 32'h0,        "read_no_ce"});
    vecs.push_back('{1, 1, A_IN,     4'hF, 32'hFFFFFFFF, ""});
    vecs.push_back('{0, 1, A_IN,     4'h0, 32'h0,        "in_write_ignored"});
    vecs.push_back('{1, 1, A_STATUS, 4'hF, 32'hFFFFFFFF, ""});
    vecs.push_back('{1, 1, A_EN,     4'hF, 32'h00000008, ""});
    vecs.push_back('{1, 1, A_EDGE,   4'hF, 32'h00000008, ""});
    vecs.push_back('{0, 1, A_EN,     4'h0, 32'h00000008, "irq_en_rw"});
    vecs.push_back('{0, 1, A_EDGE,   4'h0, 32'h00000008, "irq_edge_rw"});
    vecs.push_back('{0, 1, A_STATUS, 4'h0, 32'h0,        "cfg_no_status"});
    foreach (vecs[i]) applyStimulus(vecs[i]);
    expectNow("gpio_out_port", gpio_out, 32'h00FF00CF);
    expectNow("gpio_oe_port", gpio_oe, 32'h12345678);
    expectNow("irq_idle", {31'h0, irq}, 32'h0);

    // Synchroniser latency and rising-edge interrupt on pin 3.
    @(negedge clk);
    gpio_ce  = 1'b1;
    bus_re   = 1'b1;
    bus_addr = {27'h0, A_IN, 2'b00};
    gpio_in  = 32'h8;
    #1 expectNow("sync_edge0", bus_rdata, 32'h0);
    @(posedge clk); #1 expectNow("sync_edge1", bus_rdata, 32'h0);
    @(posedge clk); #1 expectNow("sync_edge2", bus_rdata, 32'h8);
    expectNow("irq_edge2", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 expectNow("irq_edge3", {31'h0, irq}, 32'h1);
    bus_addr = {27'h0, A_STATUS, 2'b00};
    #1 expectNow("status_edge3", bus_rdata, 32'h8);
    busIdle();

    busWrite(A_STATUS, 4'hF, 32'h8);
    busRead(A_STATUS, 1'b1, 32'h0, "w1c_clears");
    expectNow("irq_after_w1c", {31'h0, irq}, 32'h0);
    @(negedge clk) gpio_in = 32'h0;
    repeat (5) @(posedge clk);
    busRead(A_STATUS, 1'b1, 32'h0, "falling_ignored");
    expectNow("irq_falling", {31'h0, irq}, 32'h0);

    // Sticky status, then a W1C landing on the same edge as a new event.
    @(negedge clk) gpio_in = 32'h8;
    repeat (4) @(posedge clk);
    busRead(A_STATUS, 1'b1, 32'h8, "rise_again");
    @(negedge clk) gpio_in = 32'h0;
    repeat (4) @(posedge clk);
    busRead(A_STATUS, 1'b1, 32'h8, "status_sticky");
    busWrite(A_STATUS, 4'hF, 32'h8);
    busRead(A_STATUS, 1'b1, 32'h0, "w1c_before_race");
    @(negedge clk) gpio_in = 32'h8;
    @(posedge clk);
    @(posedge clk);
    busWrite(A_STATUS, 4'hF, 32'h8);
    busRead(A_STATUS, 1'b1, 32'h8, "set_beats_clear");
    expectNow("irq_after_race", {31'h0, irq}, 32'h1);

    busWrite(A_EN, 4'hF, 32'h0);
    expectNow("irq_masked", {31'h0, irq}, 32'h0);
    busRead(A_STATUS, 1'b1, 32'h8, "status_kept_masked");
    busWrite(A_EN, 4'hF, 32'h8);
    expectNow("irq_unmasked", {31'h0, irq}, 32'h1);
    busWrite(A_STATUS, 4'h0, 32'h8);
    busRead(A_STATUS, 1'b1, 32'h8, "w1c_lane_off");

    // Asynchronous reset asserted in the middle of an OUT write.
    @(negedge clk) gpio_in = 32'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gpio_ce   = 1'b1;
    bus_we    = 4'hF;
    bus_addr  = {27'h0, A_OUT, 2'b00};
    bus_wdata = 32'h55555555;
    #2 rst_n = 1'b0;
    #1 expectNow("rst_gpio_out", gpio_out, 32'h0);
    expectNow("rst_gpio_oe", gpio_oe, 32'h0);
    expectNow("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    busIdle();
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) busRead(a[2:0], 1'b1, 32'h0, $sformatf("post_rst_read%0d", a));
    expectNow("post_rst_out", gpio_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
